// File: rtl/bus_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port bus arbiter.
package bus_port_arbiter_pkg;

  localparam int BUS_W = 32;
  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] FETCH_SEL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_XFER  = 2'd1,
    ST_MEM_XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_port_arbiter.sv
// Arbitrates one external memory bus between instruction fetch and the MEM stage,
// holding stall requests until the owning stage's access completes or times out.
module bus_port_arbiter
  import bus_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_i,
  input  logic [BUS_W-1:0] if_addr_i,
  output logic [BUS_W-1:0] if_rdata_o,
  output logic             if_ready_o,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [BUS_W-1:0] mem_addr_i,
  input  logic [BUS_W-1:0] mem_wdata_i,
  input  logic [SEL_W-1:0] mem_sel_i,
  output logic [BUS_W-1:0] mem_rdata_o,
  output logic             mem_ready_o,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [BUS_W-1:0] bus_addr_o,
  output logic [BUS_W-1:0] bus_wdata_o,
  output logic [SEL_W-1:0] bus_sel_o,
  input  logic [BUS_W-1:0] bus_rdata_i,
  input  logic             bus_ack_i,
  output logic             stallreq_if_o,
  output logic             stallreq_mem_o,
  output logic             bus_err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value at which one more ack-less cycle means the limit is reached.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [BUS_W-1:0] bus_addr_q, bus_addr_d;
  logic [BUS_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
  logic [BUS_W-1:0] if_rdata_q, if_rdata_d;
  logic [BUS_W-1:0] mem_rdata_q, mem_rdata_d;
  logic             if_ready_q, if_ready_d;
  logic             mem_ready_q, mem_ready_d;
  logic             bus_err_q, bus_err_d;

  logic             timeout_hit;
  logic             xfer_done;
  logic [BUS_W-1:0] done_rdata;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign xfer_done   = bus_ack_i || timeout_hit;
  // Stores and aborted transfers hand back zero rather than whatever is on the bus.
  assign done_rdata  = (bus_ack_i && !bus_we_q) ? bus_rdata_i : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // MEM holds the older instruction, so it wins a simultaneous request.
        if (mem_req_i) begin
          state_d     = ST_MEM_XFER;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_sel_d   = mem_sel_i;
        end else if (if_req_i) begin
          state_d     = ST_IF_XFER;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_sel_d   = FETCH_SEL;
        end
      end

      ST_IF_XFER, ST_MEM_XFER: begin
        if (xfer_done) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          bus_err_d = !bus_ack_i;
          if (state_q == ST_IF_XFER) begin
            if_rdata_d = done_rdata;
            if_ready_d = 1'b1;
          end else begin
            mem_rdata_d = done_rdata;
            mem_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign bus_sel_o      = bus_sel_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign if_ready_o     = if_ready_q;
  assign mem_ready_o    = mem_ready_q;
  assign bus_err_o      = bus_err_q;
  assign stallreq_if_o  = if_req_i & ~if_ready_q;
  assign stallreq_mem_o = mem_req_i & ~mem_ready_q;

endmodule

// File: tb/tb_bus_port_arbiter.sv
// Directed bench for bus_port_arbiter: expected completions are queued as stimulus
// is driven and checked by a monitor whenever a ready pulse appears.
module tb_bus_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_mem;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bus_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_rdata_o     (if_rdata_o),
    .if_ready_o     (if_ready_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_sel_i      (mem_sel_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ready_o    (mem_ready_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_sel_o      (bus_sel_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_err_o      (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_mem, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.is_mem = is_mem;
    e.rdata  = rdata;
    e.err    = err;
    sb_q.push_back(e);
  endtask

  // Completion monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if_ready_o || mem_ready_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", {30'd0, mem_ready_o, if_ready_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ready_owner_mem", {31'd0, mem_ready_o}, {31'd0, e.is_mem});
        chk("ready_owner_if", {31'd0, if_ready_o}, {31'd0, !e.is_mem});
        chk("ready_rdata", e.is_mem ? mem_rdata_o : if_rdata_o, e.rdata);
        chk("ready_err", {31'd0, bus_err_o}, {31'd0, e.err});
      end
    end else begin
      if (bus_err_o) chk("err_without_ready", 32'd1, 32'd0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, {31'd0, bus_req_o}, 32'd0);
    chk({tag, "_bus_we"}, {31'd0, bus_we_o}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr_o, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
    chk({tag, "_bus_sel"}, {28'd0, bus_sel_o}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata_o, 32'd0);
    chk({tag, "_readys"}, {30'd0, if_ready_o, mem_ready_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus_err_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; if_req_i = 0; if_addr_i = 0; mem_req_i = 0; mem_we_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // IF only, ack two cycles after bus_req_o rises
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1 chk("if_stall_before", {31'd0, stallreq_if_o}, 32'd1);
    tick();
    chk("if_bus_req", {31'd0, bus_req_o}, 32'd1);
    chk("if_bus_addr", bus_addr_o, 32'h100);
    chk("if_bus_we", {31'd0, bus_we_o}, 32'd0);
    chk("if_bus_sel", {28'd0, bus_sel_o}, 32'hF);
    tick();
    chk("if_stall_mid", {31'd0, stallreq_if_o}, 32'd1);
    chk("if_not_ready_mid", {31'd0, if_ready_o}, 32'd0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3C01_0001;
    push(1'b0, 32'h3C01_0001, 1'b0);
    tick();
    chk("if_ready_pulse", {31'd0, if_ready_o}, 32'd1);
    chk("if_stall_released", {31'd0, stallreq_if_o}, 32'd0);
    chk("if_bus_req_cleared", {31'd0, bus_req_o}, 32'd0);
    bus_ack_i = 1'b0; if_req_i = 1'b0;
    tick();
    chk("if_ready_one_cycle", {31'd0, if_ready_o}, 32'd0);

    // Simultaneous requests: MEM first, IF next
    if_req_i = 1'b1; if_addr_i = 32'h200;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h2000; mem_sel_i = 4'hF;
    #1 chk("sim_stall_mem", {31'd0, stallreq_mem_o}, 32'd1);
    tick();
    chk("sim_first_addr", bus_addr_o, 32'h2000);
    chk("sim_first_we", {31'd0, bus_we_o}, 32'd0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    push(1'b1, 32'h1111_2222, 1'b0);
    tick();
    chk("sim_mem_stall_released", {31'd0, stallreq_mem_o}, 32'd0);
    chk("sim_if_still_stalled", {31'd0, stallreq_if_o}, 32'd1);
    chk("sim_gap_bus_req", {31'd0, bus_req_o}, 32'd0);
    bus_ack_i = 1'b0; mem_req_i = 1'b0;
    tick();
    chk("sim_second_req", {31'd0, bus_req_o}, 32'd1);
    chk("sim_second_addr", bus_addr_o, 32'h200);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_5555;
    push(1'b0, 32'hAAAA_5555, 1'b0);
    tick();
    bus_ack_i = 1'b0; if_req_i = 1'b0;
    tick();

    // Store; request dropped mid-transfer, fields must hold until ack
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h44;
    mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'b0011;
    tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_sel_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      chk("st_bus_req", {31'd0, bus_req_o}, 32'd1);
      chk("st_bus_we", {31'd0, bus_we_o}, 32'd1);
      chk("st_bus_sel", {28'd0, bus_sel_o}, 32'h3);
      chk("st_bus_addr", bus_addr_o, 32'h44);
      chk("st_bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
      if (i < 2) tick();
    end
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    push(1'b1, 32'h0, 1'b0);
    tick();
    bus_ack_i = 1'b0;
    tick();

    // Timeout with no ack: abort four cycles after bus_req_o rises
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h80; mem_sel_i = 4'hF;
    bus_rdata_i = 32'hFFFF_0000;
    tick();
    mem_req_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_bus_req_held", {31'd0, bus_req_o}, 32'd1);
      chk("to_no_err_yet", {31'd0, bus_err_o}, 32'd0);
    end
    push(1'b1, 32'h0, 1'b1);
    tick();
    chk("to_bus_req_dropped", {31'd0, bus_req_o}, 32'd0);
    chk("to_err_pulse", {31'd0, bus_err_o}, 32'd1);
    chk("to_mem_ready", {31'd0, mem_ready_o}, 32'd1);
    tick();
    chk("to_err_one_cycle", {31'd0, bus_err_o}, 32'd0);

    // Ack in the timeout cycle wins
    mem_req_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    tick(); tick(); tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5A5A_5A5A;
    push(1'b1, 32'h5A5A_5A5A, 1'b0);
    tick();
    chk("toack_no_err", {31'd0, bus_err_o}, 32'd0);
    chk("toack_ready", {31'd0, mem_ready_o}, 32'd1);
    bus_ack_i = 1'b0;
    tick();

    // Reset during the second XFER cycle, then a late ack
    if_req_i = 1'b1; if_addr_i = 32'h300;
    tick();
    chk("rst_xfer_started", {31'd0, bus_req_o}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    rst = 1'b0; if_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777;
    tick();
    chk("rst_late_ack_no_ready", {30'd0, if_ready_o, mem_ready_o}, 32'd0);
    chk("rst_late_ack_no_req", {31'd0, bus_req_o}, 32'd0);
    bus_ack_i = 1'b0;
    tick();

    // Stray ack in IDLE
    bus_ack_i = 1'b1; bus_rdata_i = 32'h9999_9999;
    tick();
    chk("stray_no_ready", {30'd0, if_ready_o, mem_ready_o}, 32'd0);
    chk("stray_no_req", {31'd0, bus_req_o}, 32'd0);
    chk("stray_no_err", {31'd0, bus_err_o}, 32'd0);
    bus_ack_i = 1'b0;
    tick();
    chk("stray_idle_after", {31'd0, bus_req_o}, 32'd0);

    tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
